// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MULT/MULTU/DIV/DIVU engine delivering a 64-bit {hi, lo} result to the hi/lo write path.
// Latency: divide 33 cycles start-to-strobe; multiply 33 cycles, or 2 when HILO_MULDIV_FAST_MUL_EN is defined.
// Backpressure: none accepted; busy stalls the pipeline while an op runs, hl_valid is a one-cycle strobe.
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [63:0] hl_data,
  output logic        hl_valid
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;      // divisor for DIV, multiplicand for MUL
  logic [63:0] acc_q, acc_d;        // {remainder, quotient} or {product hi, product lo/multiplier}
  logic        negres_q, negres_d;  // quotient / product must be negated
  logic        negrem_q, negrem_d;  // remainder must be negated
  logic [63:0] hl_data_q, hl_data_d;
  logic [63:0] hl_prev_q, hl_prev_d; // result before the latest one, restored if DONE is flushed
  logic        hl_valid_q, hl_valid_d;

  logic        div_zero, sgn_a, sgn_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic [63:0] div_step, mul_step, mul_res, div_res;

  // Operand conditioning: magnitudes and signs; divide-by-zero runs unsigned on the raw dividend
  // so the divider naturally yields hi=src_a, lo=all ones.
  always_comb begin
    div_zero = op[1] & (src_b == 32'd0);
    sgn_a    = ~op[0] & src_a[31] & ~div_zero;
    sgn_b    = ~op[0] & src_b[31];
    mag_a    = sgn_a ? (32'd0 - src_a) : src_a;
    mag_b    = sgn_b ? (32'd0 - src_b) : src_b;
  end

  // One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    rem_sh  = acc_q[63:31];
    rem_sub = rem_sh[31:0] - opnd_q;
    if (rem_sh >= {1'b0, opnd_q}) begin
      div_step = {rem_sub, acc_q[30:0], 1'b1};
    end else begin
      div_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end
  end

`ifdef HILO_MULDIV_FAST_MUL_EN
  // Full magnitude product from the synthesised multiplier in a single cycle.
  always_comb begin
    mul_step = {32'd0, opnd_q} * {32'd0, acc_q[31:0]};
  end
`else
  logic [32:0] mul_sum;
  // One shift-add step: add the multiplicand when the current multiplier bit is set, shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};
  end
`endif

  // Sign correction applied on the final step, straight into the result register.
  always_comb begin
    mul_res         = negres_q ? (64'd0 - mul_step) : mul_step;
    div_res[63:32]  = negrem_q ? (32'd0 - div_step[63:32]) : div_step[63:32];
    div_res[31:0]   = negres_q ? (32'd0 - div_step[31:0]) : div_step[31:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    negres_d   = negres_q;
    negrem_d   = negrem_q;
    hl_data_d  = hl_data_q;
    hl_prev_d  = hl_prev_q;
    hl_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          opnd_d   = op[1] ? mag_b : mag_a;
          acc_d    = {32'd0, (op[1] ? mag_a : mag_b)};
          negres_d = sgn_a ^ sgn_b;
          negrem_d = sgn_a;
          cnt_d    = 5'd0;
          state_d  = op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
`ifdef HILO_MULDIV_FAST_MUL_EN
          state_d    = S_DONE;
          hl_prev_d  = hl_data_q;
          hl_data_d  = mul_res;
          hl_valid_d = 1'b1;
`else
          acc_d = mul_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d    = S_DONE;
            hl_prev_d  = hl_data_q;
            hl_data_d  = mul_res;
            hl_valid_d = 1'b1;
          end
`endif
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d    = S_DONE;
            hl_prev_d  = hl_data_q;
            hl_data_d  = div_res;
            hl_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        // start still belongs to the finished instruction, so it is ignored here.
        state_d = S_IDLE;
        if (flush) begin
          hl_data_d = hl_prev_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      negres_q   <= 1'b0;
      negrem_q   <= 1'b0;
      hl_data_q  <= 64'd0;
      hl_prev_q  <= 64'd0;
      hl_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      negres_q   <= negres_d;
      negrem_q   <= negrem_d;
      hl_data_q  <= hl_data_d;
      hl_prev_q  <= hl_prev_d;
      hl_valid_q <= hl_valid_d;
    end
  end

  // busy is held low throughout reset even if EX still presents start.
  assign busy     = rst & (((state_q == S_IDLE) & start & ~flush) |
                           (state_q == S_MUL) | (state_q == S_DIV));
  // A flush in DONE cancels the strobe for that cycle; the data register reverts at the edge.
  assign hl_valid = hl_valid_q & ~flush;
  assign hl_data  = hl_data_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases with literal results plus randomized ops
// checked every cycle against an arithmetic reference model.
module tb_hilo_muldiv_unit;

`ifdef HILO_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy;
  logic [63:0] hl_data;
  logic        hl_valid;

  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .hl_data(hl_data), .hl_valid(hl_valid)
  );

  always #5 clk = ~clk;

  // expectations for the current cycle, written by the driver
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_valid, exp_dchk;
  logic [63:0] exp_data;
  logic        lit_en = 1'b0;
  logic [63:0] lit_val;
  string       lit_name;
  logic [63:0] last;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // compare process: mid-cycle, after combinational busy has settled
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("hl_valid", {63'd0, hl_valid}, {63'd0, exp_valid});
      if (exp_dchk) chk("hl_data", hl_data, exp_data);
      if (lit_en && hl_valid) chk(lit_name, hl_data, lit_val);
    end
  end

  // reference model: {hi, lo} straight from the arithmetic definition
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint sp;
    logic [63:0] r;
    sa = a;
    sb = b;
    r  = 64'd0;
    case (o)
      2'd0: begin sp = longint'(sa) * longint'(sb); r = sp; end
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [1:0] o);
    return o[1] ? DIV_LAT : MUL_LAT;
  endfunction

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic f, input logic eb, input logic ev, input logic [63:0] ed,
                       input logic edc);
    @(posedge clk);
    #1;
    start = s; op = o; src_a = a; src_b = b; flush = f;
    exp_busy = eb; exp_valid = ev; exp_data = ed; exp_dchk = edc;
  endtask

  task automatic idle();
    drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, 1'b0, 1'b0, last, 1'b1);
  endtask

  // one instruction held in EX from C0 to its DONE cycle; fl_at >= 0 flushes it in that cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int fl_at);
    int L;
    logic [63:0] res;
    L   = lat(o);
    res = ref_result(o, a, b);
    for (int c = 0; c <= L; c++) begin
      if (c == fl_at) begin
        drive(1'b1, o, a, b, 1'b1, (c > 0 && c < L), 1'b0, last, (c < L));
        break;
      end
      if (c < L) drive(1'b1, o, a, b, 1'b0, 1'b1, 1'b0, last, 1'b1);
      else begin
        drive(1'b1, o, a, b, 1'b0, 1'b0, 1'b1, res, 1'b1);
        last = res;
      end
    end
    if (fl_at >= 0 && fl_at <= L) idle();
  endtask

  task automatic dir(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] expv);
    lit_name = name;
    lit_val  = expv;
    lit_en   = 1'b1;
    run_op(o, a, b, -1);
    idle();
    lit_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          fl, gap;

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    last = 64'd0;
    exp_busy = 1'b0; exp_valid = 1'b0; exp_data = 64'd0; exp_dchk = 1'b1;
    // reset state, with start presented during reset
    drive(1'b1, 2'd2, 32'd5, 32'd1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    idle();

    dir("divu_100_7",     2'd3, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
    dir("div_m7_2",       2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    dir("div_ovf",        2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    dir("mult_m1_m1",     2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    dir("multu_ff_ff",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    dir("divu_by_zero",   2'd3, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF);
    dir("div_neg_by_zero",2'd2, 32'h8765_4321, 32'd0,         64'h8765_4321_FFFF_FFFF);

    // flush in C10 of a DIV: no strobe, result kept, then a fresh MULTU
    run_op(2'd2, 32'd1000, 32'd3, 10);
    dir("multu_3_5",      2'd1, 32'd3, 32'd5, 64'd15);
    // flush in the DONE cycle: strobe suppressed, previous result restored
    run_op(2'd3, 32'd50, 32'd5, DIV_LAT);
    idle();

    // reset pulse at C20 of a DIV
    for (int c = 0; c < 20; c++) drive(1'b1, 2'd2, 32'd77, 32'd3, 1'b0, 1'b1, 1'b0, last, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    last = 64'd0;
    exp_busy = 1'b0; exp_valid = 1'b0; exp_data = 64'd0; exp_dchk = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) idle();

    // randomized ops, back-to-back or with short gaps, occasional flushes
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: b = 32'($urandom_range(1, 3));
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat(o))) : -1;
      run_op(o, a, b, fl);
      gap = int'($urandom_range(0, 2));
      repeat (gap) idle();
    end

    repeat (2) idle();
    chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
